// File: rtl/score_pkg.sv
// Shared types and default constants for the score tracker.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int unsigned LIVES_W          = 4;
  localparam int unsigned DEF_SCORE_W      = 8;
  localparam int unsigned DEF_STREAK_W     = 4;
  localparam int unsigned DEF_BONUS_THRESH = 3;
  localparam int unsigned DEF_PENALTY      = 1;
  localparam int unsigned DEF_LIVES        = 3;

endpackage

// File: rtl/score_tracker_if.sv
// Control inputs and display-side outputs of the score tracker.
interface score_tracker_if
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W  = DEF_SCORE_W,
  parameter int unsigned STREAK_W = DEF_STREAK_W
);

  logic                start;
  logic                game_end;
  logic                answer_valid;
  logic                answer_correct;
  logic [SCORE_W-1:0]  score;
  logic [SCORE_W-1:0]  high_score;
  logic [STREAK_W-1:0] streak;
  logic [LIVES_W-1:0]  lives;
  logic                playing;
  logic                game_over;
  logic                new_high;

  modport master (
    output start, game_end, answer_valid, answer_correct,
    input  score, high_score, streak, lives, playing, game_over, new_high
  );

  modport slave (
    input  start, game_end, answer_valid, answer_correct,
    output score, high_score, streak, lives, playing, game_over, new_high
  );

endinterface

// File: rtl/score_sat_arith.sv
// Next-score arithmetic: saturating +1/+2 on a correct answer, floored -PENALTY otherwise.
module score_sat_arith #(
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned PENALTY = 1
) (
  input  logic [SCORE_W-1:0] score,
  input  logic               correct,
  input  logic               bonus,
  output logic [SCORE_W-1:0] score_next
);

  logic [SCORE_W:0] sum;

  always_comb begin
    sum = {1'b0, score} + (bonus ? (SCORE_W + 1)'(2) : (SCORE_W + 1)'(1));
    if (correct) begin
      score_next = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end else if (32'(score) < PENALTY) begin
      score_next = '0;
    end else begin
      score_next = score - SCORE_W'(PENALTY);
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Game session tracker: lives, streak bonus, saturating score and optional high score
// (high score built only when SCORE_TRACKER_HIGH_SCORE_EN is defined).
module score_tracker
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W      = DEF_SCORE_W,
  parameter int unsigned STREAK_W     = DEF_STREAK_W,
  parameter int unsigned BONUS_THRESH = DEF_BONUS_THRESH,
  parameter int unsigned PENALTY      = DEF_PENALTY,
  parameter int unsigned LIVES        = DEF_LIVES
) (
  input logic            clk,
  input logic            rst,
  score_tracker_if.slave bus
);

  game_state_t         state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d, score_calc;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                bonus, end_game;

  assign bonus = 32'(streak_q) >= BONUS_THRESH;

  score_sat_arith #(
    .SCORE_W (SCORE_W),
    .PENALTY (PENALTY)
  ) u_arith (
    .score      (score_q),
    .correct    (bus.answer_correct),
    .bonus      (bonus),
    .score_next (score_calc)
  );

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    streak_d = streak_q;
    lives_d  = lives_q;
    end_game = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        // A start wins over any answer strobe in the same cycle.
        if (bus.start) begin
          state_d  = PLAY;
          score_d  = '0;
          streak_d = '0;
          lives_d  = LIVES_W'(LIVES);
        end
      end
      PLAY: begin
        end_game = bus.game_end;
        if (bus.answer_valid) begin
          score_d = score_calc;
          if (bus.answer_correct) begin
            streak_d = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);
          end else begin
            streak_d = '0;
            lives_d  = lives_q - LIVES_W'(1);
            if (lives_q == LIVES_W'(1)) end_game = 1'b1;
          end
        end
        if (end_game) state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      score_q  <= '0;
      streak_q <= '0;
      lives_q  <= LIVES_W'(LIVES);
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      streak_q <= streak_d;
      lives_q  <= lives_d;
    end
  end

`ifdef SCORE_TRACKER_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;
  logic               new_high_q;

  // Compare against score_d so an answer landing with game_end is counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      new_high_q <= 1'b0;
      if (state_q == PLAY && state_d == OVER && score_d > high_q) begin
        high_q     <= score_d;
        new_high_q <= 1'b1;
      end
    end
  end

  assign bus.high_score = high_q;
  assign bus.new_high   = new_high_q;
`else
  assign bus.high_score = '0;
  assign bus.new_high   = 1'b0;
`endif

  assign bus.score     = score_q;
  assign bus.streak    = streak_q;
  assign bus.lives     = lives_q;
  assign bus.playing   = (state_q == PLAY);
  assign bus.game_over = (state_q == OVER);

endmodule
